// File: rtl/seq_restoring_divider.sv
// Sequential 8-bit by 4-bit unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; results and flags are registered and held until the next result.
module seq_restoring_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] dividend_sr;
  logic [7:0] quo_sr;
  logic [3:0] divisor_r;
  logic [3:0] rem_r;
  logic [2:0] count;

  logic       accept;
  logic       zero_div;
  logic       busy_next;
  logic       done_next;
  logic [4:0] trial;
  logic       fits;
  logic [3:0] rem_next;
  logic [7:0] quo_next;

  assign accept   = start && (state == IDLE || state == DONE);
  assign zero_div = (divisor == 4'h0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start)     state_next = zero_div ? DONE : RUN;
        else           state_next = IDLE;
      end
      RUN: begin
        if (count == 3'd0) state_next = DONE;
      end
      default:         state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  // The partial remainder is always below the divisor, so the true difference
  // fits in four bits and the low nibble of the subtraction is exact.
  always_comb begin
    trial    = {rem_r, dividend_sr[7]};
    fits     = (trial >= {1'b0, divisor_r});
    rem_next = fits ? (trial[3:0] - divisor_r) : trial[3:0];
    quo_next = {quo_sr[6:0], fits};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dividend_sr <= 8'h00;
      quo_sr      <= 8'h00;
      divisor_r   <= 4'h0;
      rem_r       <= 4'h0;
      count       <= 3'd0;
      quotient    <= 8'h00;
      remainder   <= 4'h0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
      if (accept) begin
        if (zero_div) begin
          quotient    <= 8'hFF;
          remainder   <= 4'hF;
          div_by_zero <= 1'b1;
        end else begin
          dividend_sr <= dividend;
          divisor_r   <= divisor;
          rem_r       <= 4'h0;
          quo_sr      <= 8'h00;
          count       <= 3'd7;
          div_by_zero <= 1'b0;
        end
      end else if (state == RUN) begin
        dividend_sr <= {dividend_sr[6:0], 1'b0};
        rem_r       <= rem_next;
        quo_sr      <= quo_next;
        if (count == 3'd0) begin
          quotient  <= quo_next;
          remainder <= rem_next;
        end else begin
          count <= count - 3'd1;
        end
      end
    end
  end

endmodule
